conv_lut_popacc: RTL and testbench

//  Parametrised successor to the 4-in/2-out bit LUT in the binarised conv datapath.

---
 rtl/conv_lut_popacc.sv | 183 ++++++++++++++++++
 tb/tb_conv_lut_popacc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_lut_popacc.sv
// Binarised conv dot-product: XNOR + 4-bit LUT popcount + windowed saturating accumulate.
// Optional macro CONV_BIPOLAR_OUT_EN switches the result to the signed +/-1 dot product.
module conv_lut_popacc #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int GRP_N = DATA_W / 4;
    localparam int POP_W = $clog2(DATA_W + 1);
`ifdef CONV_BIPOLAR_OUT_EN
    localparam int RW    = ACC_W + CNT_W + POP_W + 2;
`endif

    // Ones count of a 4-bit nibble, kept as an explicit LUT.
    function automatic logic [2:0] lut4_pop(input logic [3:0] nib);
        logic [2:0] cnt;
        case (nib)
            4'h0:    cnt = 3'd0;
            4'h1:    cnt = 3'd1;
            4'h2:    cnt = 3'd1;
            4'h3:    cnt = 3'd2;
            4'h4:    cnt = 3'd1;
            4'h5:    cnt = 3'd2;
            4'h6:    cnt = 3'd2;
            4'h7:    cnt = 3'd3;
            4'h8:    cnt = 3'd1;
            4'h9:    cnt = 3'd2;
            4'hA:    cnt = 3'd2;
            4'hB:    cnt = 3'd3;
            4'hC:    cnt = 3'd2;
            4'hD:    cnt = 3'd3;
            4'hE:    cnt = 3'd3;
            4'hF:    cnt = 3'd4;
            default: cnt = 3'd0;
        endcase
        return cnt;
    endfunction

    logic                   stall_s;
    logic [DATA_W-1:0]      xnor_s;
    logic [3*GRP_N-1:0]     grp_s;
    logic [3*GRP_N-1:0]     s1_grp_r;
    logic                   s1_valid_r;
    logic                   s1_last_r;
    logic [POP_W-1:0]       pop_s;
    logic [POP_W-1:0]       s2_pop_r;
    logic                   s2_valid_r;
    logic                   s2_last_r;
    logic [ACC_W-1:0]       acc_r;
    logic                   sat_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [ACC_W:0]         acc_wide_s;
    logic                   ovf_s;
    logic [ACC_W-1:0]       acc_n_s;
    logic                   cnt_sat_s;
    logic [CNT_W-1:0]       cnt_n_s;
    logic                   sat_any_s;
    logic [ACC_W-1:0]       result_s;
    logic                   load_s;
    logic                   out_valid_r;
    logic [ACC_W-1:0]       out_data_r;
    logic                   out_sat_r;

    assign stall_s   = out_valid_r & ~out_ready;
    assign in_ready  = ~stall_s & ~rst;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

    // Per-nibble match counts of the XNOR word.
    always_comb begin
        xnor_s = ~(in_data ^ in_weight);
        grp_s  = '0;
        for (int g = 0; g < GRP_N; g++) begin
            grp_s[3*g +: 3] = lut4_pop(xnor_s[4*g +: 4]);
        end
    end

    // S1 register: group counts; an idle input slot enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_grp_r   <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= in_valid;
            s1_last_r  <= in_valid & in_last;
            s1_grp_r   <= grp_s;
        end
    end

    // Sum of the group counts.
    always_comb begin
        pop_s = '0;
        for (int g = 0; g < GRP_N; g++) begin
            pop_s = pop_s + POP_W'(s1_grp_r[3*g +: 3]);
        end
    end

    // S2 register: beat popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_pop_r   <= '0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_pop_r   <= pop_s;
        end
    end

    // Saturating accumulate, beat count and window result.
    always_comb begin
        acc_wide_s = {1'b0, acc_r} + (ACC_W+1)'(s2_pop_r);
        ovf_s      = acc_wide_s[ACC_W];
        if (ovf_s) begin
            acc_n_s = {ACC_W{1'b1}};
        end else begin
            acc_n_s = acc_wide_s[ACC_W-1:0];
        end
        cnt_sat_s = (cnt_r == {CNT_W{1'b1}});
        if (cnt_sat_s) begin
            cnt_n_s = cnt_r;
        end else begin
            cnt_n_s = cnt_r + 1'b1;
        end
`ifdef CONV_BIPOLAR_OUT_EN
        sat_any_s = sat_r | ovf_s | cnt_sat_s;
        result_s  = ACC_W'(RW'({acc_n_s, 1'b0}) - RW'(DATA_W) * RW'(cnt_n_s));
`else
        sat_any_s = sat_r | ovf_s;
        result_s  = acc_n_s;
`endif
        load_s = s2_valid_r & s2_last_r & ~stall_s;
    end

    // S3: window state and the registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            sat_r       <= 1'b0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            if (s2_valid_r && !stall_s) begin
                if (s2_last_r) begin
                    out_data_r <= result_s;
                    out_sat_r  <= sat_any_s;
                    acc_r      <= '0;
                    sat_r      <= 1'b0;
                    cnt_r      <= '0;
                end else begin
                    acc_r      <= acc_n_s;
                    sat_r      <= sat_any_s;
                    cnt_r      <= cnt_n_s;
                end
            end
            // A fresh load wins over the handshake so back-to-back results never bubble.
            if (load_s) begin
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_lut_popacc.sv
// Directed bench for conv_lut_popacc: a reference model pushes expected window results,
// and a monitor pops and compares them on each output handshake.
module tb_conv_lut_popacc;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 12;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] in_weight = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;
    logic              out_sat;

    int total = 0;
    int bad   = 0;
    int m_acc = 0;
    int m_cnt = 0;
    bit m_sat = 1'b0;
    bit m_cnt_sat = 1'b0;
    logic [ACC_W:0] exp_q[$];
    int vrun = 0;
    int max_run = 0;

    conv_lut_popacc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        m_cnt_sat = 1'b0;
    endtask

    task automatic model_beat(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] w, input logic l);
        logic [ACC_W-1:0] r;
        m_acc += $countones(~(d ^ w));
        if (m_acc > 4095) begin
            m_acc = 4095;
            m_sat = 1'b1;
        end
        if (m_cnt == 255) m_cnt_sat = 1'b1;
        else m_cnt++;
        if (l) begin
`ifdef CONV_BIPOLAR_OUT_EN
            r = 12'(2 * m_acc - DATA_W * m_cnt);
            exp_q.push_back({m_sat | m_cnt_sat, r});
`else
            r = 12'(m_acc);
            exp_q.push_back({m_sat, r});
`endif
            model_clear();
        end
    endtask

    // Present one beat and hold it until accepted; leaves in_valid high for streaming.
    task automatic send(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] w, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data = d;
        in_weight = w;
        in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 60) begin
                check("send_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_beat(d, w, l);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited = 0;
        in_valid = 1'b0;
        in_last = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and out_valid run-length tracker.
    always @(negedge clk) begin
        logic [ACC_W:0] e;
        if (out_valid === 1'b1) vrun++;
        else vrun = 0;
        if (vrun > max_run) max_run = vrun;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[ACC_W-1:0]);
                check("out_sat", out_sat, e[ACC_W]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] rw;
        int len;

        // Reset state, with a beat offered during reset.
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        in_weight = 16'hFFFF;
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("post_rst_no_out", out_valid, 0);

        // Single all-match beat, latency three cycles.
        send(16'hFFFF, 16'hFFFF, 1'b1);
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("lat_t1", out_valid, 0);
        @(negedge clk);
        check("lat_t2", out_valid, 0);
        @(negedge clk);
        check("lat_t3", out_valid, 1);
        drain();

        // Three-beat window with a stray in_last while idle.
        send(16'h00FF, 16'h0000, 1'b0);
        send(16'h00FF, 16'h0000, 1'b0);
        in_valid = 1'b0;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        send(16'h00FF, 16'h0000, 1'b1);
        drain();

        // Back-to-back one-beat windows with zero matches.
        max_run = 0;
        for (int i = 0; i < 6; i++) begin
            rd = 16'hA5C3 ^ 16'(i * 16'h1111);
            send(rd, ~rd, 1'b1);
        end
        drain();
        check("b2b_valid_run", max_run, 6);

        // Backpressure: a pending result holds the pipeline for five cycles.
        out_ready = 1'b0;
        send(16'h1234, 16'h0000, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0F0F, 16'h00FF, 1'b1);
        drain();

        // Reset on beat 2 of a window drops the partial sum.
        send(16'hFFFF, 16'hFFFF, 1'b0);
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        in_weight = 16'hFFFF;
        in_last = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        idle(5);
        check("midrst_no_out", out_valid, 0);
        send(16'h0003, 16'h0000, 1'b0);
        send(16'h0003, 16'h0000, 1'b1);
        drain();

        // Random short windows.
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                rd = 16'($urandom);
                rw = 16'($urandom);
                send(rd, rw, (b == len - 1) ? 1'b1 : 1'b0);
            end
        end
        drain();

        // Long all-match window saturates the accumulator.
        for (int i = 0; i < 300; i++) begin
            send(16'hFFFF, 16'hFFFF, 1'b0);
        end
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
